// File: rtl/mem_wb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_wb_pkg : shared types for the MEM/WB skid-buffered pipeline stage   |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
package mem_wb_pkg;

  localparam int MW_DATA_W  = 32;
  localparam int MW_RADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  wb;
    logic                  memtoreg;
    logic [MW_DATA_W-1:0]  read_data;
    logic [MW_DATA_W-1:0]  alu_result;
    logic [MW_RADDR_W-1:0] rd;
  } mem_wb_bundle_t;

  // The skid entry is only ever valid while the head is valid.
  function automatic state_t state_of(input logic head_v, input logic skid_v);
    if (skid_v)      return FULL;
    else if (head_v) return ONE;
    else             return EMPTY;
  endfunction

  function automatic logic [1:0] occupancy_of(input state_t s);
    return logic'(s == FULL) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_entry.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_wb_entry : one bundle register with valid bit, load/clear enables   |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
module mem_wb_entry #(
  parameter int W = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         r_valid;
  logic [W-1:0] r_q;

  // clear wins over load; payload is kept on clear since only valid matters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else begin
      if (clear)     r_valid <= 1'b0;
      else if (load) r_valid <= 1'b1;
      if (load && !clear) r_q <= d;
    end
  end

  assign valid = r_valid;
  assign q     = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_wb_skid : MEM/WB stage, valid/ready with two-entry skid buffer      |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module mem_wb_skid
  import mem_wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int SUPPRESS_R0 = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wb,
  input  logic               in_memtoreg,
  input  logic [DATA_W-1:0]  in_read_data,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_wb,
  output logic               out_memtoreg,
  output logic [DATA_W-1:0]  out_read_data,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               wb_en,
  output logic [DATA_W-1:0]  wb_data,
  output logic [1:0]         occupancy
);

  localparam int BUNDLE_W = 2 + 2*DATA_W + RADDR_W;

  logic                r_head_v;
  logic                r_skid_v;
  logic [BUNDLE_W-1:0] r_head_q;
  logic [BUNDLE_W-1:0] r_skid_q;
  logic [BUNDLE_W-1:0] w_in_bundle;
  logic [BUNDLE_W-1:0] w_head_d;
  logic                w_accept;
  logic                w_consume;
  logic                w_head_load;
  logic                w_head_clear;
  logic                w_skid_load;
  logic                w_skid_clear;
  state_t              w_state;

  assign w_in_bundle = {in_wb, in_memtoreg, in_read_data, in_alu_result, in_rd};
  assign w_state     = state_of(r_head_v, r_skid_v);
  assign in_ready    = !r_skid_v;
  assign out_valid   = r_head_v;
  assign occupancy   = occupancy_of(w_state);
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = r_head_v && out_ready;
  assign w_head_d    = r_skid_v ? r_skid_q : w_in_bundle;

  always_comb begin
    w_head_load  = 1'b0;
    w_head_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    case (w_state)
      EMPTY: w_head_load = w_accept;
      ONE: begin
        if (w_consume) begin
          if (w_accept) w_head_load  = 1'b1;
          else          w_head_clear = 1'b1;
        end else if (w_accept) begin
          w_skid_load = 1'b1;
        end
      end
      FULL: begin
        if (w_consume) begin
          w_head_load  = 1'b1;
          w_skid_clear = 1'b1;
        end
      end
      default: ;
    endcase
    // flush overrides every transfer, including an accept in the same cycle
    if (flush) begin
      w_head_load  = 1'b0;
      w_skid_load  = 1'b0;
      w_head_clear = 1'b1;
      w_skid_clear = 1'b1;
    end
  end

  mem_wb_entry #(.W(BUNDLE_W)) u_head (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (w_head_load),
    .clear (w_head_clear),
    .d     (w_head_d),
    .valid (r_head_v),
    .q     (r_head_q)
  );

  mem_wb_entry #(.W(BUNDLE_W)) u_skid (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (w_skid_load),
    .clear (w_skid_clear),
    .d     (w_in_bundle),
    .valid (r_skid_v),
    .q     (r_skid_q)
  );

  assign {out_wb, out_memtoreg, out_read_data, out_alu_result, out_rd} = r_head_q;

  assign wb_data = out_memtoreg ? out_read_data : out_alu_result;
  assign wb_en   = out_valid && out_ready && out_wb &&
                   !((SUPPRESS_R0 != 0) && (out_rd == '0));

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mem_wb_skid : directed vector bench for mem_wb_skid                  |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module tb_mem_wb_skid;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        in_valid, in_ready, in_wb, in_memtoreg;
  logic [31:0] in_read_data, in_alu_result;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid, out_ready, out_wb, out_memtoreg;
  logic [31:0] out_read_data, out_alu_result;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_wb_skid #(.DATA_W(32), .RADDR_W(5), .SUPPRESS_R0(1)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb          (in_wb),
    .in_memtoreg    (in_memtoreg),
    .in_read_data   (in_read_data),
    .in_alu_result  (in_alu_result),
    .in_rd          (in_rd),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb         (out_wb),
    .out_memtoreg   (out_memtoreg),
    .out_read_data  (out_read_data),
    .out_alu_result (out_alu_result),
    .out_rd         (out_rd),
    .wb_en          (wb_en),
    .wb_data        (wb_data),
    .occupancy      (occupancy)
  );

  typedef struct {
    logic        iv, wb, m2r;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
    logic        ordy, fl;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [4:0]  e_rd;
    logic        e_wben;
    logic [31:0] e_wbd;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic wb, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic ordy, input logic fl);
    in_valid      = iv;
    in_wb         = wb;
    in_memtoreg   = m2r;
    in_rd         = rd;
    in_alu_result = alu;
    in_read_data  = rdata;
    out_ready     = ordy;
    flush         = fl;
  endtask

  initial begin
    // inputs (iv wb m2r rd alu rdata ordy fl) | expected (ov ir occ rd wb_en wb_data)
    vec[0]  = '{1,1,0, 3,32'h10,0,1,0,  0,1,0, 0,0,32'h0};
    vec[1]  = '{1,1,0, 4,32'h40,0,1,0,  1,1,1, 3,1,32'h10};
    vec[2]  = '{0,0,0, 0,32'h0 ,0,0,0,  1,1,1, 4,0,32'h40};
    vec[3]  = '{1,1,0, 5,32'h50,0,0,0,  1,1,1, 4,0,32'h40};
    vec[4]  = '{1,1,0, 6,32'h60,0,0,0,  1,0,2, 4,0,32'h40};
    vec[5]  = '{1,1,0, 6,32'h60,0,1,0,  1,0,2, 4,1,32'h40};
    vec[6]  = '{1,1,0, 6,32'h60,0,1,0,  1,1,1, 5,1,32'h50};
    vec[7]  = '{0,0,0, 0,32'h0 ,0,1,0,  1,1,1, 6,1,32'h60};
    vec[8]  = '{1,1,1, 0,32'h1 ,32'hDEADBEEF,0,0,  0,1,0, 6,0,32'h60};
    vec[9]  = '{0,0,0, 0,32'h0 ,0,1,0,  1,1,1, 0,0,32'hDEADBEEF};
    vec[10] = '{1,0,0, 7,32'h70,0,1,0,  0,1,0, 0,0,32'hDEADBEEF};
    vec[11] = '{0,0,0, 0,32'h0 ,0,1,0,  1,1,1, 7,0,32'h70};
    vec[12] = '{1,1,0, 8,32'h80,0,0,0,  0,1,0, 7,0,32'h70};
    vec[13] = '{1,1,0, 9,32'h90,0,0,0,  1,1,1, 8,0,32'h80};
    vec[14] = '{1,1,0,10,32'hA0,0,1,1,  1,0,2, 8,1,32'h80};
    vec[15] = '{0,0,0, 0,32'h0 ,0,1,0,  0,1,0, 8,0,32'h80};
    vec[16] = '{1,1,0, 5,32'h55,0,0,1,  0,1,0, 8,0,32'h80};
    vec[17] = '{0,0,0, 0,32'h0 ,0,1,0,  0,1,0, 8,0,32'h80};

    // reset held with a valid input present
    Rst_n = 1'b0;
    drive(1, 1, 0, 5'd3, 32'h10, 32'h0, 0, 0);
    repeat (2) @(negedge Clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_wb_data",   wb_data,        32'h0);
    check("rst_wb_en",     32'(wb_en),     32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    #1;
    check("post_rst_valid", 32'(out_valid),  32'd1);
    check("post_rst_rd",    32'(out_rd),     32'd3);
    check("post_rst_alu",   out_alu_result,  32'h10);
    check("post_rst_occ",   32'(occupancy),  32'd1);

    // clean reset between edges before the vector table
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge Clk);
      drive(vec[i].iv, vec[i].wb, vec[i].m2r, vec[i].rd, vec[i].alu, vec[i].rdata,
            vec[i].ordy, vec[i].fl);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
      check($sformatf("v%0d_in_ready",  i), 32'(in_ready),  32'(vec[i].e_ir));
      check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vec[i].e_occ));
      check($sformatf("v%0d_out_rd",    i), 32'(out_rd),    32'(vec[i].e_rd));
      check($sformatf("v%0d_wb_en",     i), 32'(wb_en),     32'(vec[i].e_wben));
      check($sformatf("v%0d_wb_data",   i), wb_data,        vec[i].e_wbd);
    end

    // streaming: one bundle per cycle, head always the previous input
    for (int i = 0; i <= 8; i++) begin
      @(negedge Clk);
      if (i < 8) drive(1, 1, 0, 5'(16 + i), 32'(32'h100 + i), 32'h0, 1, 0);
      else       drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
      #1;
      check($sformatf("s%0d_in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("s%0d_out_valid", i), 32'(out_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        check($sformatf("s%0d_out_rd", i), 32'(out_rd), 32'(15 + i));
        check($sformatf("s%0d_wb_data", i), wb_data, 32'(32'h100 + i - 1));
      end
    end
    @(negedge Clk);
    #1;
    check("s_drain_occ", 32'(occupancy), 32'd0);

    // asynchronous reset from FULL, between clock edges
    @(negedge Clk);
    drive(1, 1, 0, 5'd20, 32'h200, 32'h0, 0, 0);
    @(negedge Clk);
    drive(1, 1, 0, 5'd21, 32'h210, 32'h0, 0, 0);
    @(negedge Clk);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
    #1;
    check("full_occ",      32'(occupancy), 32'd2);
    check("full_in_ready", 32'(in_ready),  32'd0);
    #1;
    Rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid),  32'd0);
    check("arst_in_ready",  32'(in_ready),   32'd1);
    check("arst_occ",       32'(occupancy),  32'd0);
    check("arst_wb_data",   wb_data,         32'h0);
    check("arst_out_rd",    32'(out_rd),     32'd0);
    check("arst_alu",       out_alu_result,  32'h0);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    #1;
    check("post_arst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
